// File: rtl/line_draw_pkg.sv
// line_draw_pkg: shared types and constants for the line-draw arbiter.
// Coordinate widths, the latched line command record, the arbiter FSM
// state encoding and a round-robin pointer helper.
package line_draw_pkg;

  localparam int XW     = 11;
  localparam int YW     = 10;
  // Color field is stored at this width; the arbiter truncates to COLOR_W.
  localparam int CW_MAX = 32;

  typedef struct packed {
    logic [XW-1:0]     x0;
    logic [YW-1:0]     y0;
    logic [XW-1:0]     x1;
    logic [YW-1:0]     y1;
    logic [CW_MAX-1:0] color;
  } line_cmd_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    DRAW   = 2'd2,
    ACK    = 2'd3
  } arb_state_t;

  // Advance a requester index by one, wrapping at n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
// Scans req starting at rr_ptr upward with wrap and returns the first set
// bit as a one-hot grant plus its index. valid is low when req is zero.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index,
  output logic          valid
);

  // Priority scan from rr_ptr; the first hit masks all later candidates.
  always_comb begin
    logic [IW-1:0] cand;
    logic          hit;
    grant = {N{1'b0}};
    index = {IW{1'b0}};
    valid = 1'b0;
    cand  = {IW{1'b0}};
    hit   = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand        = IW'((32'(rr_ptr) + 32'(k)) % 32'(N));
      hit         = req[cand] & ~valid;
      grant[cand] = grant[cand] | hit;
      index       = hit ? cand : index;
      valid       = valid | hit;
    end
  end

endmodule

// File: rtl/line_draw_arbiter.sv
// line_draw_arbiter: shares one Bresenham engine among N_REQ requesters.
// Round-robin grant, one-cycle engine launch, plot stream forwarded as
// framebuffer writes tagged with color and owner, one-cycle ack per line.
// Optional statistics outputs (last_len, line_total) are built when the
// macro LINE_DRAW_ARB_STATS_EN is defined.
module line_draw_arbiter
  import line_draw_pkg::*;
#(
  parameter int  N_REQ   = 4,
  parameter int  COLOR_W = 16,
  localparam int ID_W    = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*XW-1:0]      req_x0,
  input  logic [N_REQ*YW-1:0]      req_y0,
  input  logic [N_REQ*XW-1:0]      req_x1,
  input  logic [N_REQ*YW-1:0]      req_y1,
  input  logic [N_REQ*COLOR_W-1:0] req_color,
  output logic [N_REQ-1:0]         ack,
  output logic                     eng_start,
  output logic [XW-1:0]            eng_x0,
  output logic [XW-1:0]            eng_x1,
  output logic [YW-1:0]            eng_y0,
  output logic [YW-1:0]            eng_y1,
  input  logic                     eng_plot,
  input  logic [XW-1:0]            eng_x,
  input  logic [YW-1:0]            eng_y,
  input  logic                     eng_done,
  output logic                     pix_we,
  output logic [XW-1:0]            pix_x,
  output logic [YW-1:0]            pix_y,
  output logic [COLOR_W-1:0]       pix_color,
  output logic [ID_W-1:0]          pix_owner,
  output logic                     busy
`ifdef LINE_DRAW_ARB_STATS_EN
  ,
  output logic [10:0]              last_len,
  output logic [15:0]              line_total
`endif
);

  arb_state_t        state_r;
  arb_state_t        state_s;
  logic [ID_W-1:0]   rr_ptr_r;
  logic [ID_W-1:0]   owner_r;
  logic [N_REQ-1:0]  owner_oh_r;
  line_cmd_t         cmd_r;
  line_cmd_t         win_cmd_s;
  logic [N_REQ-1:0]  win_grant_s;
  logic [ID_W-1:0]   win_idx_s;
  logic              win_valid_s;
  logic              grant_s;
  logic              plot_s;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (ID_W)
  ) u_rr (
    .req    (req),
    .rr_ptr (rr_ptr_r),
    .grant  (win_grant_s),
    .index  (win_idx_s),
    .valid  (win_valid_s)
  );

  // A grant happens only from IDLE; plots count only while drawing.
  assign grant_s = (state_r == IDLE) && win_valid_s;
  assign plot_s  = (state_r == DRAW) && eng_plot;

  // Engine coordinates come straight from the latched command, so they hold
  // from launch until the next grant overwrites the latch.
  assign eng_x0 = cmd_r.x0;
  assign eng_y0 = cmd_r.y0;
  assign eng_x1 = cmd_r.x1;
  assign eng_y1 = cmd_r.y1;

  // Select the winning requester's command slice.
  always_comb begin
    win_cmd_s       = '0;
    win_cmd_s.x0    = req_x0[int'(win_idx_s)*XW +: XW];
    win_cmd_s.y0    = req_y0[int'(win_idx_s)*YW +: YW];
    win_cmd_s.x1    = req_x1[int'(win_idx_s)*XW +: XW];
    win_cmd_s.y1    = req_y1[int'(win_idx_s)*YW +: YW];
    win_cmd_s.color = CW_MAX'(req_color[int'(win_idx_s)*COLOR_W +: COLOR_W]);
  end

  // Next-state logic; engine strobes outside DRAW are ignored here.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (win_valid_s) begin
          state_s = LAUNCH;
        end else begin
          state_s = IDLE;
        end
      end
      LAUNCH: state_s = DRAW;
      DRAW: begin
        if (eng_done) begin
          state_s = ACK;
        end else begin
          state_s = DRAW;
        end
      end
      ACK:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register, round-robin pointer and command latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      rr_ptr_r   <= {ID_W{1'b0}};
      owner_r    <= {ID_W{1'b0}};
      owner_oh_r <= {N_REQ{1'b0}};
      cmd_r      <= '0;
    end else begin
      state_r <= state_s;
      if (state_r == ACK) begin
        rr_ptr_r <= ID_W'(wrap_inc(int'(owner_r), N_REQ));
      end
      if (grant_s) begin
        cmd_r      <= win_cmd_s;
        owner_r    <= win_idx_s;
        owner_oh_r <= win_grant_s;
      end
    end
  end

  // Control strobes registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      eng_start <= 1'b0;
      busy      <= 1'b0;
      ack       <= {N_REQ{1'b0}};
    end else begin
      eng_start <= (state_s == LAUNCH);
      busy      <= (state_s != IDLE);
      ack       <= (state_s == ACK) ? owner_oh_r : {N_REQ{1'b0}};
    end
  end

  // Forward each engine plot as a framebuffer write one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_we    <= 1'b0;
      pix_x     <= {XW{1'b0}};
      pix_y     <= {YW{1'b0}};
      pix_color <= {COLOR_W{1'b0}};
      pix_owner <= {ID_W{1'b0}};
    end else begin
      pix_we <= plot_s;
      if (plot_s) begin
        pix_x     <= eng_x;
        pix_y     <= eng_y;
        pix_color <= COLOR_W'(cmd_r.color);
        pix_owner <= owner_r;
      end
    end
  end

`ifdef LINE_DRAW_ARB_STATS_EN
  logic [10:0] plot_cnt_r;

  // Count pixels of the current line; publish the count when the line ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      plot_cnt_r <= 11'd0;
      last_len   <= 11'd0;
      line_total <= 16'd0;
    end else begin
      if (state_r == LAUNCH) begin
        plot_cnt_r <= 11'd0;
      end else if (plot_s) begin
        plot_cnt_r <= plot_cnt_r + 11'd1;
      end
      if ((state_r == DRAW) && eng_done) begin
        last_len   <= plot_cnt_r + {10'd0, eng_plot};
        line_total <= line_total + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_line_draw_arbiter.sv
// tb_line_draw_arbiter: directed self-checking bench for line_draw_arbiter.
// Includes a behavioural Bresenham engine and a pixel/ack/start monitor.
// Define LINE_DRAW_ARB_STATS_EN to also exercise the statistics outputs.
`timescale 1ns/1ps
module tb_line_draw_arbiter;

  localparam int N = 4;
  localparam int CW = 16;

  logic          clk;
  logic          reset;
  logic [N-1:0]  req;
  logic [N*11-1:0] req_x0, req_x1;
  logic [N*10-1:0] req_y0, req_y1;
  logic [N*CW-1:0] req_color;
  logic [N-1:0]  ack;
  logic          eng_start;
  logic [10:0]   eng_x0, eng_x1, eng_x;
  logic [9:0]    eng_y0, eng_y1, eng_y;
  logic          eng_plot, eng_done;
  logic          pix_we;
  logic [10:0]   pix_x;
  logic [9:0]    pix_y;
  logic [CW-1:0] pix_color;
  logic [1:0]    pix_owner;
  logic          busy;
`ifdef LINE_DRAW_ARB_STATS_EN
  logic [10:0]   last_len;
  logic [15:0]   line_total;
`endif

  line_draw_arbiter #(.N_REQ(N), .COLOR_W(CW)) dut (
    .clk(clk), .reset(reset), .req(req),
    .req_x0(req_x0), .req_y0(req_y0), .req_x1(req_x1), .req_y1(req_y1),
    .req_color(req_color), .ack(ack), .eng_start(eng_start),
    .eng_x0(eng_x0), .eng_x1(eng_x1), .eng_y0(eng_y0), .eng_y1(eng_y1),
    .eng_plot(eng_plot), .eng_x(eng_x), .eng_y(eng_y), .eng_done(eng_done),
    .pix_we(pix_we), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
    .pix_owner(pix_owner), .busy(busy)
`ifdef LINE_DRAW_ARB_STATS_EN
    , .last_len(last_len), .line_total(line_total)
`endif
  );

  typedef struct packed {
    logic [10:0]   x;
    logic [9:0]    y;
    logic [CW-1:0] c;
    logic [1:0]    o;
  } pix_t;

  int         pass_cnt = 0;
  int         total_cnt = 0;
  int         cyc = 0;
  logic       spur = 1'b0;
  pix_t       pix_q[$];
  int         pix_cyc_q[$];
  logic [N-1:0] ack_q[$];
  int         ack_cyc_q[$];
  int         start_cyc_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: record writes, acks and launches at the falling edge.
  initial forever begin
    @(negedge clk);
    if (pix_we) begin
      pix_q.push_back({pix_x, pix_y, pix_color, pix_owner});
      pix_cyc_q.push_back(cyc);
    end
    if (ack != '0) begin
      ack_q.push_back(ack);
      ack_cyc_q.push_back(cyc);
    end
    if (eng_start) start_cyc_q.push_back(cyc);
  end

  // Behavioural Bresenham engine: one pixel per cycle, done with the last.
  initial begin
    int cx, cy, tx, ty, dx, dy, sx, sy, err, e2;
    logic active;
    active = 1'b0;
    eng_plot = 1'b0; eng_done = 1'b0; eng_x = '0; eng_y = '0;
    cx = 0; cy = 0; tx = 0; ty = 0; dx = 0; dy = 0; sx = 0; sy = 0; err = 0;
    forever begin
      @(posedge clk);
      #2;
      if (reset) begin
        active = 1'b0; eng_plot = 1'b0; eng_done = 1'b0;
      end else if (active) begin
        eng_plot = 1'b1; eng_x = 11'(cx); eng_y = 10'(cy);
        if (cx == tx && cy == ty) begin
          eng_done = 1'b1; active = 1'b0;
        end else begin
          eng_done = 1'b0;
          e2 = 2 * err;
          if (e2 >= dy) begin err += dy; cx += sx; end
          if (e2 <= dx) begin err += dx; cy += sy; end
        end
      end else if (spur) begin
        eng_plot = 1'b1; eng_done = 1'b1; eng_x = 11'd7; eng_y = 10'd7;
        spur = 1'b0;
      end else begin
        eng_plot = 1'b0; eng_done = 1'b0;
        if (eng_start) begin
          cx = int'(eng_x0); cy = int'(eng_y0);
          tx = int'(eng_x1); ty = int'(eng_y1);
          dx = (tx > cx) ? tx - cx : cx - tx;
          dy = (ty > cy) ? cy - ty : ty - cy;
          sx = (cx < tx) ? 1 : -1;
          sy = (cy < ty) ? 1 : -1;
          err = dx + dy;
          active = 1'b1;
        end
      end
    end
  end

  task automatic set_cmd(input int i, input int x0, input int y0,
                         input int x1, input int y1, input int col);
    req_x0[i*11 +: 11] = 11'(x0);
    req_y0[i*10 +: 10] = 10'(y0);
    req_x1[i*11 +: 11] = 11'(x1);
    req_y1[i*10 +: 10] = 10'(y1);
    req_color[i*CW +: CW] = CW'(col);
  endtask

  task automatic clear_q();
    pix_q.delete(); pix_cyc_q.delete();
    ack_q.delete(); ack_cyc_q.delete(); start_cyc_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_acks(input int n, input int budget, input string name);
    for (int c = 0; c < budget && ack_q.size() < n; c++) @(posedge clk);
    #1;
    total_cnt++;
    if (ack_q.size() < n)
      $display("FAIL %s: ack count %0d, required %0d", name, ack_q.size(), n);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if ({busy, ack, eng_start, pix_we} !== 7'd0)
      $display("FAIL reset_ctrl: busy/ack/start/we=%b required 0", {busy, ack, eng_start, pix_we});
    else pass_cnt++;
    total_cnt++;
    if ({eng_x0, eng_x1, eng_y0, eng_y1} !== 42'd0)
      $display("FAIL reset_eng: coords=%h required 0", {eng_x0, eng_x1, eng_y0, eng_y1});
    else pass_cnt++;
    total_cnt++;
    if ({pix_x, pix_y, pix_color, pix_owner} !== 39'd0)
      $display("FAIL reset_pix: pix=%h required 0", {pix_x, pix_y, pix_color, pix_owner});
    else pass_cnt++;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_single();
    pix_t exp;
    clear_q();
    set_cmd(0, 0, 0, 3, 0, 'h1234);
    req = 4'b0001;
    @(posedge clk); #1;
    total_cnt++;
    if ({eng_start, busy, eng_x1, eng_y1} !== {1'b1, 1'b1, 11'd3, 10'd0})
      $display("FAIL single_launch: start=%b busy=%b x1=%0d y1=%0d required 1 1 3 0",
               eng_start, busy, eng_x1, eng_y1);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if ({eng_start, eng_x1} !== {1'b0, 11'd3})
      $display("FAIL single_start_pulse: start=%b x1=%0d required 0 3", eng_start, eng_x1);
    else pass_cnt++;
    wait_acks(1, 40, "single_ack_wait");
    req = 4'b0000;
    total_cnt++;
    if (pix_q.size() != 4) $display("FAIL single_npix: %0d required 4", pix_q.size());
    else pass_cnt++;
    for (int i = 0; i < 4 && i < pix_q.size(); i++) begin
      exp = {11'(i), 10'd0, 16'h1234, 2'd0};
      total_cnt++;
      if (pix_q[i] !== exp) $display("FAIL single_pix%0d: %h required %h", i, pix_q[i], exp);
      else pass_cnt++;
    end
    total_cnt++;
    if (ack_q[0] !== 4'b0001) $display("FAIL single_ack: %b required 0001", ack_q[0]);
    else pass_cnt++;
    total_cnt++;
    if (pix_cyc_q[0] != start_cyc_q[0] + 2 || ack_cyc_q[0] != start_cyc_q[0] + 5)
      $display("FAIL single_latency: pix@%0d ack@%0d start@%0d required start+2 start+5",
               pix_cyc_q[0], ack_cyc_q[0], start_cyc_q[0]);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL single_busy: %b required 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_ack[5];
    exp_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    clear_q();
    for (int i = 0; i < N; i++) set_cmd(i, 0, 0, 1, 0, 'h100 + i);
    req = 4'b1111;
    wait_acks(5, 200, "rr_ack_wait");
    req = 4'b0000;
    for (int k = 0; k < 5 && k < ack_q.size(); k++) begin
      total_cnt++;
      if (ack_q[k] !== exp_ack[k]) $display("FAIL rr_order%0d: %b required %b", k, ack_q[k], exp_ack[k]);
      else pass_cnt++;
    end
    for (int k = 0; k < 4 && k + 1 < start_cyc_q.size(); k++) begin
      total_cnt++;
      if (start_cyc_q[k+1] != ack_cyc_q[k] + 2)
        $display("FAIL rr_restart%0d: start@%0d required %0d", k, start_cyc_q[k+1], ack_cyc_q[k] + 2);
      else pass_cnt++;
    end
    repeat (6) @(posedge clk); #1;
    total_cnt++;
    if (start_cyc_q.size() != 5) $display("FAIL rr_nstart: %0d required 5", start_cyc_q.size());
    else pass_cnt++;
    total_cnt++;
    if (pix_q.size() != 10 || pix_q[9].o !== 2'd0 || pix_q[7].c !== 16'h0103)
      $display("FAIL rr_pix: n=%0d required 10 with owner/color tags", pix_q.size());
    else pass_cnt++;
  endtask

  task automatic test_degenerate();
    clear_q();
    set_cmd(2, 5, 5, 5, 5, 'hABCD);
    req = 4'b0100;
    wait_acks(1, 40, "degen_ack_wait");
    req = 4'b0000;
    @(posedge clk); #1;
    total_cnt++;
    if (pix_q.size() != 1 || pix_q[0] !== {11'd5, 10'd5, 16'hABCD, 2'd2})
      $display("FAIL degen_pix: n=%0d first=%h required 1 write at (5,5) owner 2", pix_q.size(), pix_q[0]);
    else pass_cnt++;
    total_cnt++;
    if (ack_q[0] !== 4'b0100 || busy !== 1'b0)
      $display("FAIL degen_ack: ack=%b busy=%b required 0100 0", ack_q[0], busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    clear_q();
    set_cmd(2, 0, 0, 100, 50, 'h0F0F);
    req = 4'b0100;
    for (int c = 0; c < 40 && pix_q.size() < 3; c++) @(posedge clk);
    #1;
    total_cnt++;
    if (pix_q.size() < 3) $display("FAIL midrst_draw: %0d pixels required >=3", pix_q.size());
    else pass_cnt++;
    reset = 1'b1;
    req = 4'b0000;
    @(posedge clk); #1;
    total_cnt++;
    if ({pix_we, busy} !== 2'b00) $display("FAIL midrst_abort: we/busy=%b required 00", {pix_we, busy});
    else pass_cnt++;
    @(posedge clk); #1 reset = 1'b0;
    repeat (20) @(posedge clk); #1;
    total_cnt++;
    if (ack_q.size() != 0) $display("FAIL midrst_noack: %0d acks required 0", ack_q.size());
    else pass_cnt++;
    clear_q();
    set_cmd(2, 1, 1, 2, 2, 'h2222);
    set_cmd(3, 3, 3, 4, 3, 'h3333);
    req = 4'b1100;
    wait_acks(1, 40, "midrst_ack1_wait");
    req = 4'b1000;
    wait_acks(2, 40, "midrst_ack2_wait");
    req = 4'b0000;
    total_cnt++;
    if (ack_q[0] !== 4'b0100 || ack_q[1] !== 4'b1000)
      $display("FAIL midrst_ptr: acks %b,%b required 0100,1000", ack_q[0], ack_q[1]);
    else pass_cnt++;
    total_cnt++;
    if (pix_q.size() != 4 || pix_q[1] !== {11'd2, 10'd2, 16'h2222, 2'd2})
      $display("FAIL midrst_pix: n=%0d second=%h required 4 and (2,2) owner 2", pix_q.size(), pix_q[1]);
    else pass_cnt++;
  endtask

  task automatic test_drop_req();
    clear_q();
    set_cmd(1, 0, 0, 5, 0, 'h1111);
    set_cmd(3, 2, 0, 2, 2, 'h3333);
    req = 4'b0010;
    for (int c = 0; c < 20 && start_cyc_q.size() < 1; c++) @(posedge clk);
    #1 req = 4'b1010;
    for (int c = 0; c < 20 && pix_q.size() < 2; c++) @(posedge clk);
    #1 req = 4'b1000;
    wait_acks(2, 80, "drop_ack_wait");
    req = 4'b0000;
    total_cnt++;
    if (ack_q[0] !== 4'b0010 || ack_q[1] !== 4'b1000)
      $display("FAIL drop_acks: %b,%b required 0010,1000", ack_q[0], ack_q[1]);
    else pass_cnt++;
    total_cnt++;
    if (pix_q.size() != 9 || pix_q[5] !== {11'd5, 10'd0, 16'h1111, 2'd1}
        || pix_q[8] !== {11'd2, 10'd2, 16'h3333, 2'd3})
      $display("FAIL drop_pix: n=%0d p5=%h p8=%h required 9 pixels", pix_q.size(), pix_q[5], pix_q[8]);
    else pass_cnt++;
  endtask

  task automatic test_spurious();
    repeat (3) @(posedge clk); #1;
    clear_q();
    spur = 1'b1;
    repeat (5) @(posedge clk); #1;
    total_cnt++;
    if (pix_q.size() != 0 || ack_q.size() != 0 || busy !== 1'b0)
      $display("FAIL spurious: pix=%0d acks=%0d busy=%b required 0 0 0", pix_q.size(), ack_q.size(), busy);
    else pass_cnt++;
  endtask

`ifdef LINE_DRAW_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    clear_q();
    set_cmd(0, 0, 0, 10, 4, 'h0BEE);
    req = 4'b0001;
    wait_acks(1, 60, "stats_ack1_wait");
    req = 4'b0000;
    total_cnt++;
    if (last_len !== 11'd11 || line_total !== 16'd1)
      $display("FAIL stats_line1: last_len=%0d total=%0d required 11 1", last_len, line_total);
    else pass_cnt++;
    set_cmd(0, 7, 7, 7, 7, 'h0001);
    req = 4'b0001;
    wait_acks(2, 40, "stats_ack2_wait");
    req = 4'b0000;
    total_cnt++;
    if (last_len !== 11'd1 || line_total !== 16'd2)
      $display("FAIL stats_line2: last_len=%0d total=%0d required 1 2", last_len, line_total);
    else pass_cnt++;
  endtask
`endif

  initial begin
    reset = 1'b1; req = '0;
    req_x0 = '0; req_y0 = '0; req_x1 = '0; req_y1 = '0; req_color = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_degenerate();
    test_reset_mid();
    test_drop_req();
    test_spurious();
`ifdef LINE_DRAW_ARB_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
